// File: rtl/obi_cmd_initiator.sv
// OBI initiator: command stream in, OBI address phase out, in-order
// responses back, with outstanding tracking and a response watchdog.
module obi_cmd_initiator #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_OUT     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_we,
  input  logic [DATA_W/8-1:0] cmd_be,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                obi_req,
  input  logic                obi_gnt,
  output logic [ADDR_W-1:0]   obi_addr,
  output logic                obi_we,
  output logic [DATA_W/8-1:0] obi_be,
  output logic [DATA_W-1:0]   obi_wdata,
  input  logic                obi_rvalid,
  input  logic [DATA_W-1:0]   obi_rdata,
  output logic [2:0]          outstanding,
  output logic                timeout_err,
  output logic                proto_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      LAST    = 2'(MAX_OUT - 1);
  localparam logic [2:0]      MAX_CNT = 3'(MAX_OUT);
  localparam logic [ADDR_W-1:0] A_MASK = ~(ADDR_W'(3));

  logic [1:0]      state;
  logic [1:0]      rd_ptr;
  logic [1:0]      wr_ptr;
  logic [3:0]      tag_q;
  logic [WD_W-1:0] wd;
  logic            gnt_fire;
  logic            rv_ok;
  logic            rsp_ok;
  logic            cmd_acc;
  logic            wd_fire;
  logic [2:0]      cnt_after;

  assign obi_req = (state == ADDR);

  // rvalid with nothing counted is a protocol error and never a response
  always_comb begin
    gnt_fire  = obi_req && obi_gnt;
    rv_ok     = obi_rvalid && (outstanding != 3'd0);
    rsp_ok    = rv_ok && !timeout_err;
    cnt_after = outstanding + {2'b0, gnt_fire} - {2'b0, rv_ok};
    cmd_ready = !rst && (state != ERR)
             && ((state == IDLE) || obi_gnt)
             && (cnt_after < MAX_CNT);
    cmd_acc   = cmd_valid && cmd_ready;
    wd_fire   = !timeout_err && (outstanding != 3'd0)
             && !obi_rvalid && (wd == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      obi_addr    <= '0;
      obi_we      <= 1'b0;
      obi_be      <= '0;
      obi_wdata   <= '0;
      outstanding <= '0;
      tag_q       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      outstanding <= cnt_after;
      if (gnt_fire) begin
        tag_q[wr_ptr] <= obi_we;
        wr_ptr <= (wr_ptr == LAST) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (rv_ok)
        rd_ptr <= (rd_ptr == LAST) ? 2'd0 : rd_ptr + 2'd1;
      if (obi_rvalid && (outstanding == 3'd0))
        proto_err <= 1'b1;

      rsp_valid <= rsp_ok;
      rsp_we    <= rsp_ok && tag_q[rd_ptr];
      rsp_rdata <= (rsp_ok && !tag_q[rd_ptr]) ? obi_rdata : '0;

      if ((outstanding == 3'd0) || obi_rvalid)
        wd <= '0;
      else if (!timeout_err && (wd != WD_LAST))
        wd <= wd + 1'b1;
      if (wd_fire)
        timeout_err <= 1'b1;

      if (cmd_acc) begin
        obi_addr  <= cmd_addr & A_MASK;
        obi_we    <= cmd_we;
        obi_be    <= cmd_be;
        obi_wdata <= cmd_wdata;
      end

      if (wd_fire)
        state <= ERR;
      else if (cmd_acc)
        state <= ADDR;
      else if ((state == ADDR) && obi_gnt)
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_obi_cmd_initiator.sv
// Directed bench for obi_cmd_initiator with a behavioural OBI
// responder and an in-order response scoreboard.
module tb_obi_cmd_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_we;
  logic [3:0]    cmd_be;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          obi_req;
  logic          obi_gnt;
  logic [AW-1:0] obi_addr;
  logic          obi_we;
  logic [3:0]    obi_be;
  logic [DW-1:0] obi_wdata;
  logic          obi_rvalid;
  logic [DW-1:0] obi_rdata;
  logic [2:0]    outstanding;
  logic          timeout_err;
  logic          proto_err;

  always #5 clk = ~clk;

  obi_cmd_initiator #(
    .ADDR_W(AW), .DATA_W(DW),
    .MAX_OUT(MO), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_we(cmd_we),
    .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .obi_req(obi_req), .obi_gnt(obi_gnt),
    .obi_addr(obi_addr), .obi_we(obi_we),
    .obi_be(obi_be), .obi_wdata(obi_wdata),
    .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata),
    .outstanding(outstanding),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic we; logic [31:0] rdata; } exp_t;
  typedef struct { logic we; logic [31:0] rdata; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rsp_mem [logic [31:0]];

  logic rv_r     = 1'b0;
  logic spur_rv  = 1'b0;
  logic rv_block = 1'b0;
  int   rv_delay = 1;
  int   cyc      = 0;
  pend_t p;
  logic [31:0] old_r;

  assign obi_rvalid = rv_r | spur_rv;

  function automatic void chk(string tag, logic [95:0] obs,
                              logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] d,
                                        logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // responder: grants per obi_gnt, answers in order after rv_delay cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q.delete();
      rv_r      <= 1'b0;
      obi_rdata <= '0;
    end else begin
      cyc++;
      if (obi_req && obi_gnt) begin
        old_r = rsp_mem.exists(obi_addr) ? rsp_mem[obi_addr] : 32'h0;
        if (obi_we)
          rsp_mem[obi_addr] = merge(old_r, obi_wdata, obi_be);
        p.we    = obi_we;
        p.rdata = obi_we ? 32'hA5A5_A5A5 : old_r;
        p.due   = cyc + rv_delay - 1;
        pend_q.push_back(p);
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && !rv_block) begin
        p = pend_q.pop_front();
        rv_r      <= 1'b1;
        obi_rdata <= p.rdata;
      end else begin
        rv_r      <= 1'b0;
        obi_rdata <= '0;
      end
    end
  end

  // scoreboard: every response must match the oldest expected entry
  exp_t e;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      chk("rsp_expected", 96'(exp_q.size() > 0), 96'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", {rsp_we, rsp_rdata}, {e.we, e.rdata});
      end
    end
  end

  int   req_cyc  = 0;
  int   req_rise = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (obi_req) req_cyc++;
    if (obi_req && !req_prev) req_rise++;
    req_prev = obi_req;
  end

  task automatic send(input logic [31:0] a, input logic w,
                      input logic [3:0] be, input logic [31:0] d);
    int n;
    logic [31:0] ka;
    logic [31:0] o;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_we    = w;
    cmd_be    = be;
    cmd_wdata = d;
    #1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("cmd_accept", 96'(cmd_ready), 96'(1));
    ka = {a[31:2], 2'b00};
    o  = ref_mem.exists(ka) ? ref_mem[ka] : 32'h0;
    if (w) begin
      ref_mem[ka] = merge(o, d, be);
      exp_q.push_back('{1'b1, 32'h0});
    end else begin
      exp_q.push_back('{1'b0, o});
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 96'(exp_q.size()), 96'(0));
    repeat (2) @(negedge clk);
    chk({tag, "_out0"}, 96'(outstanding), 96'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "stuck");
  end

  initial begin
    int n;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_we    = 1'b0;
    cmd_be    = '0;
    cmd_wdata = '0;
    obi_gnt   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {cmd_ready, rsp_valid, rsp_we, obi_req, outstanding,
         timeout_err, proto_err, obi_we, obi_be, rsp_rdata, obi_addr},
        96'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {obi_req, cmd_ready}, {1'b0, 1'b1});

    // write then read back
    obi_gnt  = 1'b1;
    rv_delay = 1;
    send(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    send(32'h100, 1'b0, 4'hF, 32'h0);
    drain("wr_rd");

    // back-to-back reads
    for (int i = 0; i < 8; i++)
      send(32'h400 + 32'(4 * i), 1'b1, 4'hF, 32'h1000_0000 + 32'(i * 7));
    drain("fill");
    req_cyc  = 0;
    req_rise = 0;
    for (int i = 0; i < 8; i++)
      send(32'h400 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
    drain("b2b");
    chk("b2b_req_cycles", 96'(req_cyc), 96'(8));
    chk("b2b_req_runs", 96'(req_rise), 96'(1));

    // address phase held while grant withheld; low addr bits masked
    obi_gnt = 1'b0;
    send(32'h207, 1'b1, 4'h3, 32'h1234_5678);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold",
          {obi_req, obi_addr, obi_we, obi_be, obi_wdata},
          {1'b1, 32'h204, 1'b1, 4'h3, 32'h1234_5678});
      @(negedge clk);
    end
    obi_gnt = 1'b1;
    send(32'h204, 1'b0, 4'hF, 32'h0);
    drain("stall");

    // slow responder: limit of MAX_OUT, then gnt and rvalid together
    rv_delay = 10;
    send(32'h100, 1'b0, 4'hF, 32'h0);
    send(32'h404, 1'b0, 4'hF, 32'h0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("max_out_cnt", 96'(outstanding), 96'(2));
    chk("max_out_block", {obi_req, cmd_ready}, {1'b0, 1'b0});
    send(32'h408, 1'b0, 4'hF, 32'h0);
    chk("gnt_rv_same", {obi_req, obi_gnt, obi_rvalid, outstanding},
        {1'b1, 1'b1, 1'b1, 3'd1});
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("gnt_rv_keep", 96'(outstanding), 96'(1));
    drain("slow");

    // spurious rvalid while idle
    rv_delay = 1;
    chk("proto_clear", 96'(proto_err), 96'(0));
    spur_rv = 1'b1;
    @(negedge clk);
    spur_rv = 1'b0;
    chk("proto_set", 96'(proto_err), 96'(1));
    @(negedge clk);
    chk("spur_no_rsp", {rsp_valid, outstanding}, 96'(0));

    // reset in the middle of a burst
    rv_delay = 3;
    send(32'h500, 1'b0, 4'hF, 32'h0);
    send(32'h504, 1'b0, 4'hF, 32'h0);
    chk("pre_rst_req", 96'(obi_req), 96'(1));
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_burst",
        {cmd_ready, rsp_valid, rsp_we, obi_req, outstanding,
         timeout_err, proto_err, obi_we, obi_be, rsp_rdata, obi_addr},
        96'(0));
    exp_q.delete();
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // watchdog
    rv_delay = 1;
    rv_block = 1'b1;
    send(32'h400, 1'b0, 4'hF, 32'h0);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_early_timeout", 96'(timeout_err), 96'(0));
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_err", 96'(timeout_err), 96'(1));
    cmd_valid = 1'b1;
    #1;
    chk("err_blocked", {obi_req, cmd_ready}, {1'b0, 1'b0});
    exp_q.delete();
    rv_block = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_drain", {outstanding, proto_err, cmd_ready, obi_req},
        {3'd0, 1'b0, 1'b0, 1'b0});
    cmd_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
